return_stack: RTL and testbench

Parametrised hardware return-address stack for the instruction sequencer, successor to the fixed 16-entry call stack. It pushes `called_from + 1` on a call, presents the top entry as the return target, and pops on a return. Over the old stack it adds configurable depth and width, occupancy reporting, and full/empty status. It also adds sticky overflow/underflow error flags, tail-call handling for simultaneous call and return, and a synchronous flush. It sits between the decode stage (call/ret strobes, current PC) and the PC-select mux.

---
 rtl/return_stack_pkg.sv | 26 ++
 rtl/return_stack_mem.sv | 25 ++
 rtl/return_stack.sv | 125 ++++++++++++
 tb/tb_return_stack.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/return_stack_pkg.sv
// rtl/return_stack_pkg.sv - shared defaults, types and op decode for the return-address stack
package return_stack_pkg;

  localparam int DEFAULT_PC_WIDTH = 8;
  localparam int DEFAULT_DEPTH    = 16;

  typedef logic [DEFAULT_PC_WIDTH-1:0] pc_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } rs_op_e;

  // call+ret in the same cycle is a tail call: the current frame is replaced
  function automatic rs_op_e decode_op(input logic call, input logic ret);
    case ({call, ret})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/return_stack_mem.sv
// rtl/return_stack_mem.sv - entry array, one write port and one asynchronous read port
module return_stack_mem #(
  parameter int PC_WIDTH = 8,
  parameter int DEPTH    = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PC_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PC_WIDTH-1:0]      rdata
);

  // No reset: entries are only ever observed through the valid count.
  logic [PC_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// rtl/return_stack.sv - return-address stack top; RETURN_STACK_WRAP_EN selects circular overwrite when full
module return_stack
  import return_stack_pkg::*;
#(
  parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       flush,
  input  logic [PC_WIDTH-1:0]        called_from,
  output logic [PC_WIDTH-1:0]        return_to,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]       wp, wp_next, top_addr, waddr;
  logic [CW-1:0]       cnt, cnt_next;
  logic                ovf_q, unf_q, ovf_set, unf_set;
  logic                we, mem_we;
  logic [PC_WIDTH-1:0] wdata, rdata;
  logic                is_empty, is_full;
  rs_op_e              op;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign top_addr = wp - PW'(1);

  always_comb begin
    op       = decode_op(call, ret);
    we       = 1'b0;
    waddr    = wp;
    wdata    = called_from + PC_WIDTH'(1);
    wp_next  = wp;
    cnt_next = cnt;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!is_full) begin
          we       = 1'b1;
          wp_next  = wp + PW'(1);
          cnt_next = cnt + CW'(1);
        end else begin
          ovf_set = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
          // oldest frame sits at wp when full, so writing there drops it
          we      = 1'b1;
          wp_next = wp + PW'(1);
`endif
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          wp_next  = wp - PW'(1);
          cnt_next = cnt - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        // a tail call with nothing to replace degenerates to a plain push
        if (is_empty) begin
          we       = 1'b1;
          wp_next  = wp + PW'(1);
          cnt_next = cnt + CW'(1);
        end else begin
          we    = 1'b1;
          waddr = top_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      wp    <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp    <= wp_next;
      cnt   <= cnt_next;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign mem_we = we & ~flush & ~reset;

  return_stack_mem #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (top_addr),
    .rdata (rdata)
  );

  assign return_to = is_empty ? '0 : rdata;
  assign count     = cnt;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_return_stack.sv
// tb/tb_return_stack.sv - self-checking bench for return_stack (PC_WIDTH=8, DEPTH=4)
module tb_return_stack;

  localparam int PCW = 8;
  localparam int DEP = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           call = 1'b0, ret = 1'b0, flush = 1'b0;
  logic [PCW-1:0] called_from = '0;
  logic [PCW-1:0] return_to;
  logic [2:0]     count;
  logic           empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  // reference model: queue of frames, newest at the back
  logic [PCW-1:0] q[$];
  logic           m_ovf, m_unf;

  return_stack #(.PC_WIDTH(PCW), .DEPTH(DEP)) dut (
    .clock       (clock),
    .reset       (reset),
    .call        (call),
    .ret         (ret),
    .flush       (flush),
    .called_from (called_from),
    .return_to   (return_to),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PCW-1:0] m_top();
    return (q.size() == 0) ? '0 : q[q.size()-1];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".return_to"}, 32'(return_to), 32'(m_top()));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEP));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_apply(input logic c, input logic r, input logic f, input logic [PCW-1:0] pc);
    logic [PCW-1:0] v;
    v = pc + 8'd1;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (c && r) begin
      if (q.size() == 0) q.push_back(v);
      else q[q.size()-1] = v;
    end else if (c) begin
      if (q.size() == DEP) begin
        m_ovf = 1'b1;
`ifdef RETURN_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(v);
`endif
      end else begin
        q.push_back(v);
      end
    end else if (r) begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  // called at a negedge; applies one edge and returns at the following negedge
  task automatic step(input logic c, input logic r, input logic f, input logic [PCW-1:0] pc);
    call = c; ret = r; flush = f; called_from = pc;
    @(posedge clock);
    model_apply(c, r, f, pc);
    @(negedge clock);
    call = 1'b0; ret = 1'b0; flush = 1'b0;
  endtask

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(negedge clock);
    check_all("in_reset");
    reset = 1'b0;
    check_all("reset_vals");

    step(1, 0, 0, 8'h10); chk("push1.top", 32'(return_to), 32'h11);
    step(1, 0, 0, 8'h20); chk("push2.top", 32'(return_to), 32'h21);
    step(1, 0, 0, 8'h30); chk("push3.top", 32'(return_to), 32'h31);
    chk("push3.count", 32'(count), 32'd3);
    check_all("after_pushes");
    chk("pop1.pre", 32'(return_to), 32'h31); step(0, 1, 0, 8'h00);
    chk("pop2.pre", 32'(return_to), 32'h21); step(0, 1, 0, 8'h00);
    chk("pop3.pre", 32'(return_to), 32'h11); step(0, 1, 0, 8'h00);
    chk("popped.empty", 32'(empty), 32'd1);
    chk("popped.top", 32'(return_to), 32'd0);
    check_all("after_pops");

    step(1, 0, 0, 8'hFF);
    chk("wrap_pc.top", 32'(return_to), 32'h00);
    chk("wrap_pc.count", 32'(count), 32'd1);
    step(0, 0, 1, 8'h00);

    for (int i = 1; i <= 5; i++) step(1, 0, 0, PCW'(i));
    check_all("overfull");
    chk("overfull.ovf", 32'(overflow), 32'd1);
`ifdef RETURN_STACK_WRAP_EN
    chk("overfull.top", 32'(return_to), 32'h06);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_ret", 32'(return_to), 32'(6 - i));
      step(0, 1, 0, 8'h00);
    end
`else
    chk("overfull.top", 32'(return_to), 32'h05);
    chk("overfull.full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drop_ret", 32'(return_to), 32'(5 - i));
      step(0, 1, 0, 8'h00);
    end
`endif
    step(0, 1, 0, 8'h00);
    chk("under.flag", 32'(underflow), 32'd1);
    chk("under.count", 32'(count), 32'd0);
    check_all("underflow");
    step(0, 0, 1, 8'h00);
    chk("flush.ovf", 32'(overflow), 32'd0);
    chk("flush.unf", 32'(underflow), 32'd0);

    step(1, 0, 0, 8'h40);
    step(1, 1, 0, 8'h80);
    chk("tail.count", 32'(count), 32'd1);
    chk("tail.top", 32'(return_to), 32'h81);
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h20);
    chk("tail_empty.count", 32'(count), 32'd1);
    chk("tail_empty.top", 32'(return_to), 32'h21);
    chk("tail_empty.unf", 32'(underflow), 32'd0);
    check_all("tail_calls");

    // full-stack tail call must not raise overflow
    for (int i = 0; i < 3; i++) step(1, 0, 0, PCW'(8'h60 + i));
    step(1, 1, 0, 8'h90);
    chk("tail_full.top", 32'(return_to), 32'h91);
    check_all("tail_full");

    step(0, 0, 1, 8'h00);
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    #1 reset = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_all("async_reset");
    reset = 1'b0;
    @(negedge clock);
    step(1, 0, 0, 8'h50);
    chk("post_reset.top", 32'(return_to), 32'h51);
    chk("post_reset.count", 32'(count), 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic c, r, f;
      c = ($urandom_range(0, 99) < 50);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      step(c, r, f, PCW'($urandom));
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
